// File: rtl/rhs_burst_pkg.sv
// Shared types for the RHS burst accumulator slice.
//   rhs_op_e      : per-beat RHS operation selector (2 bits)
//   burst_state_e : burst control FSM states
package rhs_burst_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 2'd0,
    OP_MIX  = 2'd1,
    OP_FLAG = 2'd2,
    OP_MUX  = 2'd3
  } rhs_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2
  } burst_state_e;

endpackage

// File: rtl/rhs_op_unit.sv
// Combinational RHS evaluator for one operand beat.
//   in_a, in_b, in_c : DATA_W operands (in_c only used by OP_MIX)
//   in_sel           : mux select / flag qualifier
//   in_op            : operation select
//   res              : DATA_W result, wraps mod 2^DATA_W
//   eq               : in_a == in_b, independent of the selected op
module rhs_op_unit
  import rhs_burst_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_c,
  input  logic              in_sel,
  input  rhs_op_e           in_op,
  output logic [DATA_W-1:0] res,
  output logic              eq
);

  always_comb begin
    eq  = (in_a == in_b);
    res = '0;
    unique case (in_op)
      OP_ADD:  res = in_a + in_b;
      OP_MIX:  res = (in_a - in_b) ^ ~in_c;
      OP_FLAG: res[0] = eq & in_sel;
      OP_MUX:  res = in_sel ? in_a : in_b;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/rhs_burst_accumulator.sv
// Accumulates BURST_LEN evaluated RHS beats into a wide sum and presents the
// burst total on a valid/ready output.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input beat handshake (in_ready decoded from state)
//   in_a, in_b, in_c    : operands; in_sel select/qualifier; in_op operation
//   out_valid/out_ready : burst result handshake
//   out_acc             : sum of per-beat results, mod 2^ACC_W
//   out_flag            : OR over the burst of (in_a == in_b)
//   out_beats           : beats accepted in the current burst
module rhs_burst_accumulator
  import rhs_burst_pkg::*;
#(
  parameter  int unsigned DATA_W    = 8,
  parameter  int unsigned ACC_W     = 16,
  parameter  int unsigned BURST_LEN = 4,
  localparam int unsigned CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_c,
  input  logic              in_sel,
  input  logic [1:0]        in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_flag,
  output logic [CNT_W-1:0]  out_beats
);

  burst_state_e        state;
  logic [DATA_W-1:0]   beat_res;
  logic                beat_eq;
  logic                beat_accept;
  logic [ACC_W-1:0]    beat_ext;
  logic [CNT_W-1:0]    count_next;
  logic                burst_done;

  rhs_op_unit #(.DATA_W(DATA_W)) u_op (
    .in_a   (in_a),
    .in_b   (in_b),
    .in_c   (in_c),
    .in_sel (in_sel),
    .in_op  (rhs_op_e'(in_op)),
    .res    (beat_res),
    .eq     (beat_eq)
  );

  // in_ready is gated by rst_n so it reads 0 for the whole reset interval,
  // not just once the state register has settled.
  assign in_ready    = rst_n && (state != ST_EMIT);
  assign beat_accept = in_valid && in_ready;
  assign beat_ext    = ACC_W'(beat_res);
  assign count_next  = out_beats + CNT_W'(1);
  assign burst_done  = (count_next == CNT_W'(BURST_LEN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_acc   <= '0;
      out_flag  <= 1'b0;
      out_beats <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (beat_accept) begin
            out_acc   <= beat_ext;
            out_flag  <= beat_eq;
            out_beats <= CNT_W'(1);
            if (BURST_LEN == 1) begin
              state     <= ST_EMIT;
              out_valid <= 1'b1;
            end else begin
              state <= ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          if (beat_accept) begin
            out_acc   <= out_acc + beat_ext;
            out_flag  <= out_flag | beat_eq;
            out_beats <= count_next;
            if (burst_done) begin
              state     <= ST_EMIT;
              out_valid <= 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_acc   <= '0;
            out_flag  <= 1'b0;
            out_beats <= '0;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_acc   <= '0;
          out_flag  <= 1'b0;
          out_beats <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
